// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Write-port match helper is used by both the bypass mux and busy clear.
package regfile_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NREG_DEF  = 32;
  localparam int MAX_NWR   = 16;
  localparam int MAX_AW    = 16;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } wr_hit_t;

  typedef logic [MAX_NWR-1:0][MAX_AW-1:0] wr_addr_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

  // Highest-index enabled port targeting a wins.
  function automatic wr_hit_t wr_match(
    input logic [MAX_NWR-1:0] en,
    input wr_addr_t           addr,
    input logic [MAX_AW-1:0]  a
  );
    wr_hit_t h;
    h = '0;
    for (int j = 0; j < MAX_NWR; j++) begin
      if (en[j] && addr[j] == a) begin
        h.hit = 1'b1;
        h.idx = 4'(j);
      end
    end
    return h;
  endfunction

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Busy-bit scoreboard: writeback clears, allocation sets, set wins.
// Register 0 is never marked busy when it is hardwired to zero.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREG     = NREG_DEF,
  parameter  int NWR      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  output logic              alloc_ok,
  output logic [NREG-1:0]   busy_vec
);

  logic [NREG-1:0]    r_busy;
  logic [NREG-1:0]    w_clr;
  logic [NREG-1:0]    w_set;
  logic [NREG-1:0]    w_nxt;
  logic [MAX_NWR-1:0] w_wen;
  wr_addr_t           w_wadr;
  logic               w_zero;
  wr_hit_t            w_h [NREG];

  always_comb begin
    w_wen  = '0;
    w_wadr = '0;
    for (int j = 0; j < NWR; j++) begin
      w_wen[j]  = wr_en[j];
      w_wadr[j] = MAX_AW'(wr_addr[j*AW +: AW]);
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_h[r]   = wr_match(w_wen, w_wadr, MAX_AW'(r));
      w_clr[r] = w_h[r].hit;
    end
  end

  assign w_zero = (ZERO_REG != 0) && (alloc_addr == '0);

  assign alloc_ok = alloc_en & ~rst &
                    (w_zero | ~r_busy[alloc_addr] | w_clr[alloc_addr]);

  always_comb begin
    w_set = '0;
    if (alloc_ok && !w_zero)
      w_set[alloc_addr] = 1'b1;
  end

  assign w_nxt = (r_busy & ~w_clr) | w_set;

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_nxt;
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write bypass and scoreboard.
// Data array, write priority and read muxes live here.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = WIDTH_DEF,
  parameter  int NREG     = NREG_DEF,
  parameter  int NRD      = 2,
  parameter  int NWR      = 2,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  output logic                 alloc_ok,
  output logic [NREG-1:0]      busy_vec
);

  logic [WIDTH-1:0]   r_rf [NREG];
  logic [MAX_NWR-1:0] w_wen;
  wr_addr_t           w_wadr;
  logic [NREG-1:0]    w_busy;
  logic               w_whit [NREG];
  logic [3:0]         w_widx [NREG];
  wr_hit_t            w_wh   [NREG];
  wr_hit_t            w_rh   [NRD];
  logic [AW-1:0]      w_ra   [NRD];

  always_comb begin
    w_wen  = '0;
    w_wadr = '0;
    for (int j = 0; j < NWR; j++) begin
      w_wen[j]  = wr_en[j];
      w_wadr[j] = MAX_AW'(wr_addr[j*AW +: AW]);
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_wh[r]   = wr_match(w_wen, w_wadr, MAX_AW'(r));
      w_whit[r] = w_wh[r].hit && !((ZERO_REG != 0) && r == 0);
      w_widx[r] = w_wh[r].idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        r_rf[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        if (w_whit[r])
          r_rf[r] <= wr_data[w_widx[r]*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      w_ra[i] = rd_addr[i*AW +: AW];
      w_rh[i] = wr_match(w_wen, w_wadr, MAX_AW'(w_ra[i]));
      if (!((ZERO_REG != 0) && w_ra[i] == '0)) begin
        if ((BYPASS != 0) && w_rh[i].hit)
          rd_data[i*WIDTH +: WIDTH] = wr_data[w_rh[i].idx*WIDTH +: WIDTH];
        else
          rd_data[i*WIDTH +: WIDTH] = r_rf[w_ra[i]];
        rd_busy[i] = w_busy[w_ra[i]] & ~((BYPASS != 0) && w_rh[i].hit);
      end
    end
  end

  regfile_scoreboard #(
    .NREG     (NREG),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .alloc_ok   (alloc_ok),
    .busy_vec   (w_busy)
  );

  assign busy_vec = w_busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed plus randomized bench for regfile_mp_sb.
// Reference model keeps register values and busy flags as plain arrays.
module tb_regfile_mp_sb;

  localparam int WIDTH = 32;
  localparam int NREG  = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*WIDTH-1:0] wr_data;
  logic                 alloc_en;
  logic [AW-1:0]        alloc_addr;
  logic                 alloc_ok;
  logic [NREG-1:0]      busy_vec;

  logic [WIDTH-1:0] m_rf [NREG];
  logic [NREG-1:0]  m_busy;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp_sb #(
    .WIDTH(WIDTH), .NREG(NREG), .NRD(NRD), .NWR(NWR),
    .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .alloc_ok   (alloc_ok),
    .busy_vec   (busy_vec)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int match_port(input logic [AW-1:0] a);
    int m;
    m = -1;
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] == a) m = j;
    return m;
  endfunction

  function automatic logic exp_alloc_ok();
    return alloc_en && !rst &&
      (alloc_addr == 0 || !m_busy[alloc_addr] || match_port(alloc_addr) >= 0);
  endfunction

  task automatic idle();
    rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0;
  endtask

  // Let combinational outputs settle, then compare against the model.
  task automatic settle();
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] ed;
    logic             eb;
    int               m;
    #2;
    for (int i = 0; i < NRD; i++) begin
      a = rd_addr[i*AW +: AW];
      if (a == 0) begin
        ed = '0; eb = 1'b0;
      end else begin
        m = match_port(a);
        if (m >= 0) begin
          ed = wr_data[m*WIDTH +: WIDTH]; eb = 1'b0;
        end else begin
          ed = m_rf[a]; eb = m_busy[a];
        end
      end
      if (!rst) begin
        chk($sformatf("rd_data%0d", i), 64'(rd_data[i*WIDTH +: WIDTH]), 64'(ed));
        chk($sformatf("rd_busy%0d", i), 64'(rd_busy[i]), 64'(eb));
      end
    end
    chk("alloc_ok", 64'(alloc_ok), 64'(exp_alloc_ok()));
    chk("busy_vec", 64'(busy_vec), 64'(m_busy));
  endtask

  // Apply the architectural effect of this cycle to the model, then clock.
  task automatic commit();
    logic ok;
    logic [AW-1:0] a;
    ok = exp_alloc_ok();
    if (rst) begin
      for (int r = 0; r < NREG; r++) m_rf[r] = '0;
      m_busy = '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        a = wr_addr[j*AW +: AW];
        if (wr_en[j] && a != 0) begin
          m_rf[a]   = wr_data[j*WIDTH +: WIDTH];
          m_busy[a] = 1'b0;
        end
      end
      if (ok && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) m_rf[r] = '0;
    m_busy = '0;
    idle();
    rd_addr = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    commit();
    idle();

    rd_addr = {5'd5, 5'd0};
    settle();
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    chk("reset_rd_busy", 64'(rd_busy), 64'd0);
    chk("reset_busy_vec", 64'(busy_vec), 64'd0);
    commit();

    wr_en = 2'b11; wr_addr = {5'd3, 5'd3};
    wr_data = {32'h0000AAAA, 32'h00005555};
    rd_addr = {5'd3, 5'd3};
    settle();
    chk("prio_bypass", 64'(rd_data[31:0]), 64'h0000AAAA);
    commit();
    idle();
    settle();
    chk("prio_reg", 64'(rd_data[63:32]), 64'h0000AAAA);
    commit();

    wr_en = 2'b01; wr_addr = '0; wr_data = {32'h0, 32'h0000DEAD};
    alloc_en = 1'b1; alloc_addr = 5'd0; rd_addr = '0;
    settle();
    chk("zero_alloc_ok", 64'(alloc_ok), 64'd1);
    chk("zero_rd", 64'(rd_data), 64'd0);
    commit();
    idle();
    settle();
    chk("zero_busy0", 64'(busy_vec[0]), 64'd0);
    chk("zero_rd_after", 64'(rd_data[31:0]), 64'd0);
    commit();

    alloc_en = 1'b1; alloc_addr = 5'd7;
    settle();
    chk("x7_alloc_ok", 64'(alloc_ok), 64'd1);
    commit();
    rd_addr = {5'd7, 5'd7};
    settle();
    chk("x7_rd_busy", 64'(rd_busy), 64'd3);
    chk("x7_realloc_ok", 64'(alloc_ok), 64'd0);
    commit();
    idle();
    settle();
    chk("x7_busy_vec", 64'(busy_vec), 64'h80);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h12};
    settle();
    chk("x7_wb_rd_busy", 64'(rd_busy[0]), 64'd0);
    chk("x7_wb_rd_data", 64'(rd_data[31:0]), 64'h12);
    commit();
    idle();
    settle();
    chk("x7_busy_clr", 64'(busy_vec[7]), 64'd0);
    commit();

    alloc_en = 1'b1; alloc_addr = 5'd9;
    settle(); commit();
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h99, 32'h0};
    settle();
    chk("x9_alloc_ok", 64'(alloc_ok), 64'd1);
    commit();
    idle();
    rd_addr = {5'd0, 5'd9};
    settle();
    chk("x9_busy", 64'(busy_vec[9]), 64'd1);
    chk("x9_data", 64'(rd_data[31:0]), 64'h99);
    commit();

    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h77};
    alloc_en = 1'b1; alloc_addr = 5'd4;
    settle(); commit();
    idle();
    rst = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd4};
    wr_data = {32'h0, 32'h88}; alloc_en = 1'b1; alloc_addr = 5'd10;
    settle();
    chk("rst_alloc_ok", 64'(alloc_ok), 64'd0);
    commit();
    idle();
    rd_addr = {5'd9, 5'd4};
    settle();
    chk("rst_x4", 64'(rd_data[31:0]), 64'd0);
    chk("rst_busy_vec", 64'(busy_vec), 64'd0);
    commit();

    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      wr_en = NWR'($urandom);
      for (int j = 0; j < NWR; j++) begin
        wr_addr[j*AW +: AW]    = AW'($urandom_range(0, 15));
        wr_data[j*WIDTH +: WIDTH] = $urandom;
      end
      for (int i = 0; i < NRD; i++)
        rd_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
      alloc_en = $urandom_range(0, 1) == 1;
      alloc_addr = AW'($urandom_range(0, 15));
      settle();
      commit();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
